conv1d_mac_ctrl: RTL and testbench
==================================

Name: conv1d_mac_ctrl

Overview:
Control and sequencing stage directly upstream of the 1D-convolution MAC. It walks input/filter memory addresses for each output window and drives the MAC's enable/clear strobes with the multiplier pipeline delay matched. It captures each finished accumulator value into a 2-entry output FIFO with a valid/ready handshake. One conv1d_mac_ctrl pairs with one MAC instance plus two external 1-cycle-latency read memories (x and w).

Parameters:
N, 16, input vector length (x memory depth)
M, 4, filter taps (w memory depth); 2 <= M <= N
MULT_STAGES, 2, stages of the MAC's pipelined multiplier; multiplier latency MULT_LAT = MULT_STAGES-1
ACC_W, 28, MAC accumulator width
OUT_DEPTH, 2, output FIFO entries

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a convolution; sampled only in IDLE
busy  out  1  high from accepted start until final output consumed
done  out  1  one-cycle pulse in the cycle after the final output handshake
addr_x  out  $clog2(N)  x memory read address
addr_w  out  $clog2(M)  w memory read address
enable_mult  out  1  MAC multiplier enable
en_pipeline_reg  out  1  MAC product register enable
en_acc  out  1  MAC accumulator enable
clear_reg  out  1  MAC product register clear
clear_acc  out  1  MAC accumulator clear
f  in  ACC_W signed  MAC accumulator value
out_data  out  ACC_W signed  head of output FIFO
out_valid  out  1  output FIFO non-empty
out_ready  in  1  downstream accepts out_data

Behaviour:
- Reset: FSM to IDLE; all outputs 0; FIFO emptied; delay line flushed; counters 0. A reset mid-operation aborts the job; no done pulse.
- FSM: IDLE -> (start) INIT -> ISSUE <-> GAP -> DRAIN -> IDLE.
- INIT (1 cycle): pulse clear_reg and clear_acc; window j=0, tap i=0.
- ISSUE: each cycle drive addr_x=j+i, addr_w=i (correlation order, no tap reversal) and push an issue token into the delay line; i increments. The token at i=M-1 is tagged last. After i=M-1, go to GAP.
- GAP (1 cycle, mandatory bubble): no issue. This separates consecutive windows so that clear_acc never coincides with an en_acc. Then j increments. If j < N-M, enter ISSUE (subject to the credit rule); otherwise enter DRAIN.
- Credit rule: a window starts ISSUE only if (windows in flight + FIFO occupancy) < OUT_DEPTH. Otherwise the FSM holds in GAP with addresses frozen and no tokens issued.
- Delay line, for a token issued in cycle k:
  - enable_mult=1 in cycle k+1 (memory data valid).
  - en_pipeline_reg=1 in cycle k+1+MULT_LAT.
  - en_acc=1 in cycle k+2+MULT_LAT.
  - f holds the final window sum in cycle k+3+MULT_LAT for a last-tagged token.
  - In that cycle: push f into the FIFO and pulse clear_acc.
- The FIFO is never pushed when full; the credit rule guarantees this. Pushing when full is an assertion failure.
- Pop on out_valid && out_ready. Simultaneous push and pop on a full FIFO is legal.
- No arithmetic in this block. Saturation is done by the MAC; f is passed through unmodified.
- Outputs per job: N-M+1, in window order.
- Latency with out_ready=1: start accepted in cycle 0, first issue in cycle 1, first out_valid in cycle M+MULT_LAT+4.
- Throughput: one output per M+1 cycles.
- DRAIN: wait until in-flight count is 0 and FIFO is empty. done pulses the cycle after the last pop; busy falls the same cycle done rises.
- start while busy is ignored.

Decomposition:
- Package conv1d_pkg: state enum (IDLE, INIT, ISSUE, GAP, DRAIN), MULT_LAT derivation, ACC_W constant.
- Sub-module conv1d_out_fifo: parameterised depth/width sync FIFO with valid/ready pop, full/empty/count outputs.

Test Plan:
- Basic: N=8, M=4, x=1..8, w=1,1,1,1, out_ready=1, bench MAC plus memory models -> outputs 10,14,18,22,26; first out_valid in cycle 9; done pulses once; busy low afterwards.
- Weighted: x=1..8, w=1,2,3,4 -> outputs 30,40,50,60,70.
- Saturation: all x=8191, w=8191, M=4 -> every output 134217727 (28'h7FFFFFF); all signs negative -> 28'h8000000.
- Backpressure: out_ready=0 from start -> at most 2 outputs buffered and addr_x frozen. Release out_ready -> all 5 outputs in order with no loss or duplicate; toggle out_ready randomly for a second run with the same result.
- Reset mid-job: assert reset during ISSUE of window 2 -> next cycle all outputs 0, out_valid=0, no done. A new start produces the correct full sequence.
- Strobe timing: check that clear_acc never coincides with en_acc and that en_acc count per window equals M, via assertion over all scenarios.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared types and constants for the 1D-convolution MAC controller.
package conv1d_pkg;

    // Default MAC accumulator width.
    localparam int CONV_ACC_W = 28;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ISSUE = 3'd2,
        GAP   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // The first multiplier stage is the operand capture; the rest is latency.
    function automatic int mult_lat(input int mult_stages);
        return mult_stages - 1;
    endfunction

endpackage

// File: rtl/conv1d_out_fifo.sv
// Small synchronous FIFO that holds finished window sums.
// The head is presented with valid/ready; it is popped on valid && ready.
module conv1d_out_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 28
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop_ready,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign head_valid = !empty;
    // Head reads as zero when empty so out_data is clean after reset.
    assign head_data  = empty ? '0 : mem[rd_ptr];
    assign pop        = head_valid && pop_ready;

    // Storage write; data words need no reset since occupancy gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv1d_mac_ctrl.sv
// Address walker and strobe sequencer for a pipelined 1D-convolution MAC.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; all strobes low
//   INIT  | one cycle: clear product register and accumulator, reset i/j
//   ISSUE | one tap per cycle: addr_x=j+i, addr_w=i, token into delay line
//   GAP   | bubble between windows; holds here while out of credit
//   DRAIN | all windows issued; wait for in-flight and FIFO to empty
module conv1d_mac_ctrl
    import conv1d_pkg::*;
#(
    parameter int N           = 16,
    parameter int M           = 4,
    parameter int MULT_STAGES = 2,
    parameter int ACC_W       = CONV_ACC_W,
    parameter int OUT_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(N)-1:0]    addr_x,
    output logic [$clog2(M)-1:0]    addr_w,
    output logic                    enable_mult,
    output logic                    en_pipeline_reg,
    output logic                    en_acc,
    output logic                    clear_reg,
    output logic                    clear_acc,
    input  logic signed [ACC_W-1:0] f,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int XW  = $clog2(N);
    localparam int WW  = $clog2(M);
    localparam int LAT = mult_lat(MULT_STAGES);
    // Token positions: 0 = memory data valid, LAT = product reg,
    // LAT+1 = accumulate, LAT+2 = final sum visible on f.
    localparam int DL  = LAT + 3;
    localparam int CW  = $clog2(OUT_DEPTH + 1);

    state_t          state;
    state_t          state_nxt;
    logic [XW-1:0]   j;
    logic [WW-1:0]   i;
    logic [CW-1:0]   inflight;
    logic [DL-1:0]   tok_v;
    logic [DL-1:0]   tok_last;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            issue;
    logic            last_tap;
    logic            start_win;
    logic            credit_ok;
    logic            drain_ok;
    logic            push;
    logic            pop;

    assign last_tap  = (i == WW'(M - 1));
    // A window may start only if its result is guaranteed a FIFO slot.
    assign credit_ok = (int'(inflight) + int'(fifo_count)) < OUT_DEPTH;
    assign drain_ok  = (inflight == '0) && fifo_empty;
    assign push      = tok_v[DL-1] && tok_last[DL-1];
    assign pop       = out_valid && out_ready;

    assign addr_x          = j + XW'(i);
    assign addr_w          = i;
    assign enable_mult     = tok_v[0];
    assign en_pipeline_reg = tok_v[LAT];
    assign en_acc          = tok_v[LAT+1];
    assign clear_reg       = (state == INIT);
    // Capturing a sum also wipes the accumulator for the next window; the
    // GAP bubble keeps this cycle free of en_acc.
    assign clear_acc       = (state == INIT) || push;
    assign done            = (state == DRAIN) && drain_ok;
    assign busy            = (state != IDLE) && !done;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        start_win = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                // Nothing is in flight and the FIFO is empty here.
                state_nxt = ISSUE;
                start_win = 1'b1;
            end
            ISSUE: begin
                issue = 1'b1;
                if (last_tap) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (j < XW'(N - M)) begin
                    if (credit_ok) begin
                        state_nxt = ISSUE;
                        start_win = 1'b1;
                    end
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Tap/window counters and windows-in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            i        <= '0;
            j        <= '0;
            inflight <= '0;
        end else begin
            case (state)
                INIT: begin
                    i <= '0;
                    j <= '0;
                end
                ISSUE: i <= last_tap ? '0 : i + WW'(1);
                GAP: begin
                    if (state_nxt == ISSUE) begin
                        j <= j + XW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        j <= '0;
                    end
                end
                default: ;
            endcase
            case ({start_win, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Delay line matching the memory, multiplier and accumulator latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            tok_v    <= '0;
            tok_last <= '0;
        end else begin
            tok_v    <= {tok_v[DL-2:0], issue};
            tok_last <= {tok_last[DL-2:0], issue && last_tap};
        end
    end

    conv1d_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ACC_W)
    ) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (f),
        .pop_ready  (out_ready),
        .head_data  (out_data),
        .head_valid (out_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // The credit scheme must never let a sum arrive at a full FIFO.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (reset) push |-> (!fifo_full || pop)
    );

endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// Bench for conv1d_mac_ctrl with x/w memory and saturating MAC models.
module tb_conv1d_mac_ctrl;

    localparam int N    = 8;
    localparam int M    = 4;
    localparam int NOUT = N - M + 1;
    localparam int LIM  = 3000;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               busy;
    logic               done;
    logic [2:0]         addr_x;
    logic [1:0]         addr_w;
    logic               enable_mult;
    logic               en_pipeline_reg;
    logic               en_acc;
    logic               clear_reg;
    logic               clear_acc;
    logic signed [27:0] f;
    logic signed [27:0] out_data;
    logic               out_valid;
    logic               out_ready;

    conv1d_mac_ctrl #(
        .N           (N),
        .M           (M),
        .MULT_STAGES (2),
        .ACC_W       (28),
        .OUT_DEPTH   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .addr_x          (addr_x),
        .addr_w          (addr_w),
        .enable_mult     (enable_mult),
        .en_pipeline_reg (en_pipeline_reg),
        .en_acc          (en_acc),
        .clear_reg       (clear_reg),
        .clear_acc       (clear_acc),
        .f               (f),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x[8];
        int w[4];
        int exp[5];
        int mode;   // 0: always ready, 1: random ready, 2: stalled then released
    } vec_t;

    vec_t   tbl[7];
    int     expq[$];
    int     nvec = 0;
    int     nmis = 0;
    int     nout = 0;
    int     ndone = 0;
    int     npush = 0;
    int     en_cnt = 0;

    // Memory and MAC models
    int     xmem[8];
    int     wmem[4];
    int     xd = 0, wd = 0, prod_s = 0, preg = 0;
    longint acc_m = 0;

    function automatic longint sat28(input longint v);
        if (v > 134217727)  return 134217727;
        if (v < -134217728) return -134217728;
        return v;
    endfunction

    always @(posedge clk) begin
        xd <= xmem[addr_x];
        wd <= wmem[addr_w];
        if (enable_mult) prod_s <= xd * wd;
        if (clear_reg) preg <= 0;
        else if (en_pipeline_reg) preg <= prod_s;
        if (clear_acc) acc_m <= 0;
        else if (en_acc) acc_m <= sat28(acc_m + longint'(preg));
    end

    assign f = acc_m[27:0];

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: each handshake pops the next expected window sum.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check($sformatf("out%0d", nout), out_data, expq.pop_front());
            end
            nout++;
        end
    end

    always @(negedge clk) begin
        if (!reset && done) begin
            ndone++;
            check("done_busy", busy, 0);
        end
    end

    // Strobe rules: no en_acc with clear_acc; M accumulates per window.
    always @(negedge clk) begin
        if (reset) begin
            en_cnt = 0;
        end else if (clear_acc) begin
            check("strobe_overlap", en_acc, 0);
            check("en_acc_per_window", en_cnt, clear_reg ? 0 : M);
            if (!clear_reg) npush++;
            en_cnt = 0;
        end else if (en_acc) begin
            en_cnt++;
        end
    end

    task automatic check_idle(input string nm);
        @(negedge clk);
        check({nm, "_strobes"}, longint'({busy, done, enable_mult, en_pipeline_reg,
                                          en_acc, clear_reg, clear_acc, out_valid}), 0);
        check({nm, "_addr_x"}, addr_x, 0);
        check({nm, "_addr_w"}, addr_w, 0);
        check({nm, "_out_data"}, out_data, 0);
    endtask

    task automatic run_job(input int v);
        int c;
        int first_valid;
        int a1;
        int a2;
        int stall_push;
        xmem = tbl[v].x;
        wmem = tbl[v].w;
        for (int k = 0; k < NOUT; k++) expq.push_back(tbl[v].exp[k]);
        nout = 0; ndone = 0; npush = 0;
        c = 0; first_valid = -1; a1 = -1; a2 = -2; stall_push = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy && c < LIM) begin
            case (tbl[v].mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = 1'($urandom_range(0, 1));
                    start = (c == 20);
                end
                default: out_ready = (c >= 40);
            endcase
            @(negedge clk);
            if (out_valid && first_valid < 0) first_valid = c;
            if (c == 30) a1 = int'(addr_x);
            if (c == 38) begin
                a2 = int'(addr_x);
                stall_push = npush;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check($sformatf("v%0d_busy_timeout", v), (c < LIM), 1);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("v%0d_out_count", v), nout, NOUT);
        check($sformatf("v%0d_done_count", v), ndone, 1);
        check($sformatf("v%0d_busy_low", v), busy, 0);
        check($sformatf("v%0d_queue_left", v), expq.size(), 0);
        if (tbl[v].mode == 0) check($sformatf("v%0d_first_valid", v), first_valid, 9);
        if (tbl[v].mode == 2) begin
            check($sformatf("v%0d_stall_buffered", v), stall_push, 2);
            check($sformatf("v%0d_addr_frozen", v), a2, a1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[0].w = '{1, 1, 1, 1};
        tbl[0].exp = '{10, 14, 18, 22, 26};
        tbl[0].mode = 0;
        tbl[1].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[1].w = '{1, 2, 3, 4};
        tbl[1].exp = '{30, 40, 50, 60, 70};
        tbl[1].mode = 0;
        tbl[2].x = '{8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191};
        tbl[2].w = '{8191, 8191, 8191, 8191};
        tbl[2].exp = '{134217727, 134217727, 134217727, 134217727, 134217727};
        tbl[2].mode = 0;
        tbl[3].x = '{-8191, -8191, -8191, -8191, -8191, -8191, -8191, -8191};
        tbl[3].w = '{8191, 8191, 8191, 8191};
        tbl[3].exp = '{-134217728, -134217728, -134217728, -134217728, -134217728};
        tbl[3].mode = 0;
        tbl[4].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[4].w = '{1, 2, 3, 4};
        tbl[4].exp = '{30, 40, 50, 60, 70};
        tbl[4].mode = 2;
        tbl[5].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[5].w = '{1, 2, 3, 4};
        tbl[5].exp = '{30, 40, 50, 60, 70};
        tbl[5].mode = 1;
        tbl[6].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[6].w = '{2, -1, 0, 3};
        tbl[6].exp = '{12, 16, 20, 24, 28};
        tbl[6].mode = 1;

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("reset");

        for (int v = 0; v < 7; v++) run_job(v);

        // Reset while window 2 is issuing (cycles 11..14 after start).
        xmem = tbl[0].x;
        wmem = tbl[0].w;
        for (int k = 0; k < NOUT; k++) expq.push_back(tbl[0].exp[k]);
        ndone = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete();
        check_idle("mid_reset");
        repeat (20) @(posedge clk);
        #1;
        check("mid_reset_no_done", ndone, 0);
        run_job(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
